adc_sclk_frame_gen: RTL and testbench
=====================================

Name: adc_sclk_frame_gen

Overview:
- Parametrised serial-clock and frame sequencer for SPI-style ADCs.
- Divides the system clock by a runtime divisor and produces:
  - an SCLK level;
  - one-cycle rising-edge and falling-edge clock-enable strobes;
  - chip-select and bit index;
  - framing of FRAME_BITS-bit conversions, in single-shot or continuous mode, with abort.
- Sits between the system clock domain and the ADC shift-register/deserialiser. That logic uses the strobes as clock enables and never uses SCLK as a clock.

Parameters:
- CNT_W, 8, width of the divider counter and of div_i.
- DIV_DEFAULT, 24, divisor used while div_i is 0.
- DIV_MIN, 4, minimum legal divisor; smaller non-zero values are clamped to it.
- FRAME_BITS, 16, SCLK periods per frame.
- BIT_W, 5, width of bit_idx; must satisfy 2^BIT_W >= FRAME_BITS.

Ports:
- clk_clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- div_i  in  CNT_W  SCLK period in clk_clk cycles; sampled only on frame start.
- start_i  in  1  one-cycle request to start a frame; honoured only in IDLE.
- cont_i  in  1  continuous mode; sampled at the end of GAP.
- abort_i  in  1  synchronous abort.
- sclk  out  1  ADC serial clock; idle level is 0.
- pe_sclk  out  1  one-cycle strobe at the SCLK rising edge.
- ne_sclk  out  1  one-cycle strobe at the SCLK falling edge.
- cs_n  out  1  active-low chip select.
- bit_idx  out  BIT_W  index of the current SHIFT bit, 0..FRAME_BITS-1.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset values (asynchronous, active-low): state=IDLE, cnt=0, bit_idx=0, cs_n=1, sclk=0, pe_sclk=0, ne_sclk=0, busy=0, frame_done=0.
- Divisor latch, on IDLE->SETUP:
  - div_i==0 -> latch DIV_DEFAULT.
  - 0<div_i<DIV_MIN -> latch DIV_MIN.
  - otherwise latch div_i.
  - half = div>>1; odd divisors give a longer low phase.
- Divider counter:
  - Runs 0..div-1, wraps to 0, and resets to 0 on every state transition.
  - Frozen at 0 in IDLE.
- States: IDLE, SETUP, SHIFT, HOLD, GAP. Every state other than IDLE lasts a whole number of div periods.
- IDLE:
  - start_i=1 and abort_i=0 -> SETUP on the next cycle.
  - The cycle after start_i is the first cycle with cs_n=0.
- SETUP:
  - cs_n=0, sclk=0.
  - Lasts div cycles, then -> SHIFT.
- SHIFT:
  - cs_n=0.
  - sclk=1 while cnt<half, else 0.
  - pe_sclk=1 when cnt==0; ne_sclk=1 when cnt==half.
  - bit_idx increments when cnt==div-1.
  - When cnt==div-1 and bit_idx==FRAME_BITS-1 -> HOLD, bit_idx returns to 0, and frame_done=1 for the first HOLD cycle.
- HOLD:
  - cs_n=0, sclk=0.
  - Lasts div cycles, then -> GAP.
- GAP:
  - cs_n=1, sclk=0.
  - Lasts div cycles.
  - At the end: cont_i=1 and no abort -> SETUP, reusing the already-latched div; otherwise -> IDLE.
- Output timing: all outputs are registered or decoded from registered state/cnt. No combinational path from any input to any output.
- Abort:
  - abort_i=1 in SETUP, SHIFT or HOLD -> GAP on the next cycle, with cs_n=1, sclk=0 and bit_idx=0.
  - No frame_done is issued for an aborted frame.
  - GAP then always exits to IDLE.
  - abort_i in GAP forces exit to IDLE.
  - abort_i in IDLE is a no-op.
- Simultaneous events:
  - start_i and abort_i together in IDLE -> abort wins; state stays IDLE.
  - start_i while busy is ignored; it is not queued.
- Reset asserted mid-frame: immediate return to reset values. Release resumes in IDLE.
- Strobe counts: exactly FRAME_BITS pe_sclk and FRAME_BITS ne_sclk pulses per complete frame, and none outside SHIFT.

Decomposition:
- Package adc_sclk_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the default-divisor and minimum-divisor constants;
  - a clamp function for the divisor.
- Sub-module adc_div_cnt provides:
  - the divisor latch/clamp, the counter, and the terminal-count and half-count flags;
  - inputs clk_clk, reset_n, load, clear, run.
- The parent owns the FSM, bit_idx and output decode.

Test Plan:
- Reset, default settings (div_i=0), start_i at cycle T:
  - cs_n low T+1..T+432.
  - First pe_sclk at T+25, first ne_sclk at T+37.
  - 16 pe_sclk and 16 ne_sclk pulses in total.
  - frame_done at T+409.
  - cs_n high T+433..T+456; busy low at T+457.
- div_i=2 -> clamped to 4:
  - sclk pattern 1,1,0,0 in SHIFT.
  - SHIFT lasts 64 cycles; frame_done at T+69.
- div_i=5 (odd):
  - sclk high 2 cycles, low 3 cycles.
  - ne_sclk at cnt==2.
  - Frame length 5*(1+16+1+1)=95 cycles.
- cont_i=1 with div=24:
  - Successive cs_n falling edges 456 cycles apart.
  - cs_n high for exactly 24 cycles between frames.
  - Clearing cont_i mid-frame ends after the current GAP.
- abort_i at SHIFT bit_idx=7:
  - Next cycle cs_n=1, sclk=0, bit_idx=0.
  - No frame_done.
  - IDLE after 24 GAP cycles even with cont_i=1.
- Boundary cases:
  - start_i while busy is ignored.
  - start_i and abort_i together in IDLE leaves busy=0.
  - reset_n pulsed low mid-SHIFT returns all outputs to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/adc_sclk_pkg.sv
// Shared definitions for the ADC serial-clock / frame sequencer.
package adc_sclk_pkg;

  // Fixed state encodings, kept stable for existing users of the codes.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD,
    GAP   = ST_GAP
  } state_e;

  localparam int unsigned DIV_DEFAULT_C = 24;
  localparam int unsigned DIV_MIN_C     = 4;

  // Zero selects the default divisor; small non-zero values are raised to the minimum.
  function automatic int unsigned clamp_div(input int unsigned div,
                                            input int unsigned dflt,
                                            input int unsigned dmin);
    if (div == 0) return dflt;
    if (div < dmin) return dmin;
    return div;
  endfunction

endpackage

// File: rtl/adc_sclk_frame_gen_if.sv
// Control/status bundle between a host and the ADC frame sequencer.
interface adc_sclk_frame_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned BIT_W = 5
) ();

  logic [CNT_W-1:0] div_i;
  logic             start_i;
  logic             cont_i;
  logic             abort_i;
  logic             sclk;
  logic             pe_sclk;
  logic             ne_sclk;
  logic             cs_n;
  logic [BIT_W-1:0] bit_idx;
  logic             busy;
  logic             frame_done;

  modport master (
    output div_i, start_i, cont_i, abort_i,
    input  sclk, pe_sclk, ne_sclk, cs_n, bit_idx, busy, frame_done
  );

  modport slave (
    input  div_i, start_i, cont_i, abort_i,
    output sclk, pe_sclk, ne_sclk, cs_n, bit_idx, busy, frame_done
  );

endinterface

// File: rtl/adc_div_cnt.sv
// Divisor latch and SCLK period counter with zero/half/terminal flags.
module adc_div_cnt
  import adc_sclk_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_C,
  parameter int unsigned DIV_MIN     = DIV_MIN_C
) (
  input  logic             clk_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] div_i,
  output logic             zc,
  output logic             hc,
  output logic             tc,
  output logic             lo_half
);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;

  assign half    = div_q >> 1;
  assign zc      = (cnt == '0);
  assign hc      = (cnt == half);
  assign tc      = (cnt == div_q - CNT_W'(1));
  assign lo_half = (cnt < half);

  // Capture the clamped divisor when a new frame sequence starts.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n)  div_q <= CNT_W'(DIV_DEFAULT);
    else if (load) div_q <= CNT_W'(clamp_div(32'(div_i), DIV_DEFAULT, DIV_MIN));
  end

  // Count 0..div-1 while running; any state change restarts the period.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/adc_sclk_frame_gen.sv
// SPI-style ADC serial-clock and frame sequencer (SETUP/SHIFT/HOLD/GAP).
module adc_sclk_frame_gen
  import adc_sclk_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_C,
  parameter int unsigned DIV_MIN     = DIV_MIN_C,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned BIT_W       = 5
) (
  input logic                 clk_clk,
  input logic                 reset_n,
  adc_sclk_frame_gen_if.slave bus
);

  state_e           state;
  state_e           state_nxt;
  logic             abort_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic             zc, hc, tc, lo_half;
  logic             last_bit;

  assign last_bit = (bit_idx_q == BIT_W'(FRAME_BITS - 1));

  adc_div_cnt #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .DIV_MIN     (DIV_MIN)
  ) u_div_cnt (
    .clk_clk (clk_clk),
    .reset_n (reset_n),
    .load    ((state == IDLE) && (state_nxt == SETUP)),
    .clear   (state_nxt != state),
    .run     (state != IDLE),
    .div_i   (bus.div_i),
    .zc      (zc),
    .hc      (hc),
    .tc      (tc),
    .lo_half (lo_half)
  );

  // Next-state decode; abort pulls any active phase into GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i && !bus.abort_i) state_nxt = SETUP;
      SETUP:   if (bus.abort_i) state_nxt = GAP;
               else if (tc)     state_nxt = SHIFT;
      SHIFT:   if (bus.abort_i)          state_nxt = GAP;
               else if (tc && last_bit)  state_nxt = HOLD;
      HOLD:    if (bus.abort_i || tc) state_nxt = GAP;
      GAP:     if (bus.abort_i) state_nxt = IDLE;
               else if (tc)     state_nxt = (bus.cont_i && !abort_q) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Remember that the current GAP follows an abort so it cannot chain into SETUP.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n)                           abort_q <= 1'b0;
    else if (state_nxt != GAP)              abort_q <= 1'b0;
    else if (bus.abort_i && state != GAP)   abort_q <= 1'b1;
  end

  // Bit index advances at each SHIFT period end and is zero outside SHIFT.
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n)                   bit_idx_q <= '0;
    else if (state_nxt != SHIFT)    bit_idx_q <= '0;
    else if (state == SHIFT && tc)  bit_idx_q <= bit_idx_q + BIT_W'(1);
  end

  // Outputs are pure decodes of registered state and counter.
  assign bus.sclk       = (state == SHIFT) && lo_half;
  assign bus.pe_sclk    = (state == SHIFT) && zc;
  assign bus.ne_sclk    = (state == SHIFT) && hc;
  assign bus.cs_n       = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign bus.bit_idx    = bit_idx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == HOLD) && zc;

endmodule

// File: tb/tb_adc_sclk_frame_gen.sv
// Scoreboard bench for adc_sclk_frame_gen: expected strobe/edge events are
// queued with absolute cycle numbers when a frame is launched and matched by a monitor.
module tb_adc_sclk_frame_gen;

  localparam int EV_CSF  = 0;
  localparam int EV_PE   = 1;
  localparam int EV_NE   = 2;
  localparam int EV_DONE = 3;
  localparam int EV_CSR  = 4;
  localparam int EV_IDLE = 5;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  ev_t  q[$];
  logic prev_cs_n = 1'b1;
  logic prev_busy = 1'b0;
  logic [5:0] obs;
  ev_t  mon_e;

  adc_sclk_frame_gen_if #(.CNT_W(8), .BIT_W(5)) bus ();

  adc_sclk_frame_gen #(
    .CNT_W       (8),
    .DIV_DEFAULT (24),
    .DIV_MIN     (4),
    .FRAME_BITS  (16),
    .BIT_W       (5)
  ) dut (
    .clk_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: detect events on the falling edge and match them against the queue.
  always @(negedge clk) begin
    obs[EV_CSF]  = prev_cs_n && !bus.cs_n;
    obs[EV_PE]   = bus.pe_sclk;
    obs[EV_NE]   = bus.ne_sclk;
    obs[EV_DONE] = bus.frame_done;
    obs[EV_CSR]  = !prev_cs_n && bus.cs_n;
    obs[EV_IDLE] = prev_busy && !bus.busy;
    prev_cs_n = bus.cs_n;
    prev_busy = bus.busy;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_event: kind %0d required at cycle %0d, not observed by cycle %0d",
                 q[0].kind, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      for (int k = 0; k < 6; k++) begin
        if (obs[k]) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", k, cyc);
          end else begin
            mon_e = q.pop_front();
            if (mon_e.kind !== k || mon_e.cyc !== cyc) begin
              miscompares++;
              $display("FAIL event_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                       k, cyc, mon_e.kind, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  function automatic int eff_div(input int d);
    if (d == 0) return 24;
    if (d < 4) return 4;
    return d;
  endfunction

  function automatic void push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  // n back-to-back frames launched by a start sampled in cycle s.
  function automatic void push_frames(input int s, input int d, input int n);
    int de, h, b;
    de = eff_div(d);
    h  = de / 2;
    for (int f = 0; f < n; f++) begin
      b = s + f * 19 * de;
      push_ev(EV_CSF, b + 1);
      for (int k = 0; k < 16; k++) begin
        push_ev(EV_PE, b + 1 + de + k * de);
        push_ev(EV_NE, b + 1 + de + k * de + h);
      end
      push_ev(EV_DONE, b + 1 + 17 * de);
      push_ev(EV_CSR,  b + 1 + 18 * de);
    end
    push_ev(EV_IDLE, s + 1 + n * 19 * de);
  endfunction

  task automatic kick(input int d, input int n, output int s);
    @(negedge clk);
    s = cyc;
    push_frames(s, d, n);
    bus.div_i   = 8'(d);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input int quiet);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, required 0", q.size(), budget);
      q.delete();
    end
    repeat (quiet) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    bus.div_i   = '0;
    bus.start_i = 1'b0;
    bus.cont_i  = 1'b0;
    bus.abort_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.sclk, bus.pe_sclk, bus.ne_sclk, bus.cs_n, bus.bit_idx, bus.busy, bus.frame_done}
        !== 11'b000_1_00000_0_0) begin
      miscompares++;
      $display("FAIL reset_values: got %b, required %b",
               {bus.sclk, bus.pe_sclk, bus.ne_sclk, bus.cs_n, bus.bit_idx, bus.busy, bus.frame_done},
               11'b000_1_00000_0_0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_default_div;
    int s;
    bus.cont_i = 1'b0;
    kick(0, 1, s);
    goto_cyc(s + 408);
    vectors++;
    if (bus.bit_idx !== 5'd15 || bus.cs_n !== 1'b0) begin
      miscompares++;
      $display("FAIL default_last_bit: got bit_idx=%0d cs_n=%b, required 15/0", bus.bit_idx, bus.cs_n);
    end
    goto_cyc(s + 457);
    vectors++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL default_idle: got busy=%b cs_n=%b, required 0/1", bus.busy, bus.cs_n);
    end
    wait_drain(100, 30);
  endtask

  task automatic test_clamp_div2;
    int s;
    logic [7:0] pat;
    pat = 8'b1100_1100;
    kick(2, 1, s);
    goto_cyc(s + 5);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus.sclk !== pat[7-i]) begin
        miscompares++;
        $display("FAIL clamp_sclk[%0d]: got %b, required %b", i, bus.sclk, pat[7-i]);
      end
      @(negedge clk);
    end
    wait_drain(200, 12);
  endtask

  task automatic test_odd_div5;
    int s;
    logic [9:0] pat;
    pat = 10'b11000_11000;
    kick(5, 1, s);
    goto_cyc(s + 6);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.sclk !== pat[9-i]) begin
        miscompares++;
        $display("FAIL odd_sclk[%0d]: got %b, required %b", i, bus.sclk, pat[9-i]);
      end
      @(negedge clk);
    end
    wait_drain(200, 15);
  endtask

  task automatic test_continuous;
    int s;
    bus.cont_i = 1'b1;
    kick(0, 2, s);
    bus.div_i = 8'd4;
    goto_cyc(s + 456);
    vectors++;
    if (bus.cs_n !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_gap_end: got cs_n=%b busy=%b, required 1/1", bus.cs_n, bus.busy);
    end
    goto_cyc(s + 457);
    vectors++;
    if (bus.cs_n !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_restart: got cs_n=%b, required 0", bus.cs_n);
    end
    goto_cyc(s + 556);
    bus.cont_i = 1'b0;
    bus.div_i  = '0;
    wait_drain(1000, 30);
  endtask

  task automatic test_abort;
    int s, a;
    bus.cont_i = 1'b1;
    @(negedge clk);
    s = cyc;
    a = s + 196;
    push_ev(EV_CSF, s + 1);
    for (int k = 0; k < 8; k++) begin
      push_ev(EV_PE, s + 25 + 24 * k);
      if (k < 7) push_ev(EV_NE, s + 37 + 24 * k);
    end
    push_ev(EV_CSR, a + 1);
    push_ev(EV_IDLE, a + 25);
    bus.div_i   = '0;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    goto_cyc(a);
    vectors++;
    if (bus.bit_idx !== 5'd7 || bus.sclk !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got bit_idx=%0d sclk=%b, required 7/1", bus.bit_idx, bus.sclk);
    end
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    vectors++;
    if ({bus.cs_n, bus.sclk, bus.bit_idx, bus.frame_done} !== 8'b1_0_00000_0) begin
      miscompares++;
      $display("FAIL abort_post: got %b, required %b",
               {bus.cs_n, bus.sclk, bus.bit_idx, bus.frame_done}, 8'b1_0_00000_0);
    end
    wait_drain(100, 30);
    bus.cont_i = 1'b0;
  endtask

  task automatic test_start_while_busy;
    int s;
    kick(4, 1, s);
    goto_cyc(s + 20);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    goto_cyc(s + 74);
    vectors++;
    if (bus.busy !== 1'b1 || bus.cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_gap: got busy=%b cs_n=%b, required 1/1", bus.busy, bus.cs_n);
    end
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_drain(100, 40);
  endtask

  task automatic test_start_abort_idle;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL start_abort_idle: got busy=%b cs_n=%b, required 0/1", bus.busy, bus.cs_n);
    end
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_in_idle: got busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_async_reset;
    int s;
    kick(4, 1, s);
    goto_cyc(s + 17);
    vectors++;
    if ({bus.busy, bus.cs_n, bus.sclk, bus.pe_sclk} !== 4'b1011) begin
      miscompares++;
      $display("FAIL pre_reset_shift: got %b, required 1011",
               {bus.busy, bus.cs_n, bus.sclk, bus.pe_sclk});
    end
    mon_en = 1'b0;
    q.delete();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.sclk, bus.pe_sclk, bus.ne_sclk, bus.cs_n, bus.bit_idx, bus.busy, bus.frame_done}
        !== 11'b000_1_00000_0_0) begin
      miscompares++;
      $display("FAIL async_reset: got %b, required %b",
               {bus.sclk, bus.pe_sclk, bus.ne_sclk, bus.cs_n, bus.bit_idx, bus.busy, bus.frame_done},
               11'b000_1_00000_0_0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b cs_n=%b, required 0/1", bus.busy, bus.cs_n);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_clamp_div2();
    test_odd_div5();
    test_continuous();
    test_abort();
    test_start_while_busy();
    test_start_abort_idle();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
